// File: rtl/stage_id_pipe_if.sv
// Decode-stage bus bundle.
// Groups the IF/ID input, writeback port, downstream controls and the registered
// ID/EX outputs of stage_id_pipe.
//   master : the surrounding pipeline (drives id_*, w_regs_*, ex_hold, flush)
//   slave  : stage_id_pipe (drives id_stall and all ex_* fields)
interface stage_id_pipe_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned PCW  = 32
);
  localparam int unsigned RAW = $clog2(NREG);

  logic            id_valid;
  logic [31:0]     id_inst;
  logic [PCW-1:0]  id_pc;
  logic            w_regs_en;
  logic [RAW-1:0]  w_regs_addr;
  logic [XLEN-1:0] w_regs_data;
  logic            ex_hold;
  logic            flush;

  logic            id_stall;
  logic            ex_valid;
  logic [PCW-1:0]  ex_pc;
  logic [XLEN-1:0] ex_regs_data1;
  logic [XLEN-1:0] ex_regs_data2;
  logic [XLEN-1:0] ex_imm;
  logic [2:0]      ex_func3_code;
  logic            ex_func7_code;
  logic [RAW-1:0]  ex_rd;
  logic [RAW-1:0]  ex_rs1;
  logic [RAW-1:0]  ex_rs2;
  logic            ex_br;
  logic            ex_mem_read;
  logic            ex_mem2reg;
  logic            ex_mem_write;
  logic            ex_alu_src;
  logic            ex_regs_write;
  logic [2:0]      ex_alu_op;

  modport master (
    output id_valid, id_inst, id_pc, w_regs_en, w_regs_addr, w_regs_data, ex_hold, flush,
    input  id_stall, ex_valid, ex_pc, ex_regs_data1, ex_regs_data2, ex_imm, ex_func3_code,
           ex_func7_code, ex_rd, ex_rs1, ex_rs2, ex_br, ex_mem_read, ex_mem2reg,
           ex_mem_write, ex_alu_src, ex_regs_write, ex_alu_op
  );

  modport slave (
    input  id_valid, id_inst, id_pc, w_regs_en, w_regs_addr, w_regs_data, ex_hold, flush,
    output id_stall, ex_valid, ex_pc, ex_regs_data1, ex_regs_data2, ex_imm, ex_func3_code,
           ex_func7_code, ex_rd, ex_rs1, ex_rs2, ex_br, ex_mem_read, ex_mem2reg,
           ex_mem_write, ex_alu_src, ex_regs_write, ex_alu_op
  );
endinterface

// File: rtl/stage_id_pipe.sv
// RISC-V decode stage: register file with write-through bypass, control decode,
// immediate generation, load-use hazard detection and the ID/EX register
// (hold / bubble / flush).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : stage_id_pipe_if.slave (IF/ID input, writeback, ex_hold, flush,
//              id_stall and the registered ex_* outputs)
// Optional: define STAGE_ID_PERF_EN to add saturating counters
//   perf_bubbles (hazard bubbles loaded) and perf_flushes (flush edges).
module stage_id_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned PCW  = 32
) (
  input logic           clk,
  input logic           rst,
  stage_id_pipe_if.slave bus
`ifdef STAGE_ID_PERF_EN
  ,
  output logic [31:0]   perf_bubbles,
  output logic [31:0]   perf_flushes
`endif
);
  localparam int unsigned RAW = $clog2(NREG);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;

  typedef struct packed {
    logic            valid;
    logic [PCW-1:0]  pc;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic [XLEN-1:0] imm;
    logic [2:0]      f3;
    logic            f7;
    logic [RAW-1:0]  rd;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic            br;
    logic            mem_read;
    logic            mem2reg;
    logic            mem_write;
    logic            alu_src;
    logic            regs_write;
    logic [2:0]      alu_op;
  } ex_t;

  logic [31:0]     inst;
  logic [RAW-1:0]  rs1_idx, rs2_idx;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            rs1_used, rs2_used, hazard;
  ex_t             dec, ex_d, ex_q;

  assign inst    = bus.id_inst;
  assign rs1_idx = inst[15 +: RAW];
  assign rs2_idx = inst[20 +: RAW];

  // Register file; entry 0 is never written so it stays at its reset value.
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (bus.w_regs_en && bus.w_regs_addr != '0) regs_d[bus.w_regs_addr] = bus.w_regs_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports with write-through so a same-cycle writeback is seen by decode.
  always_comb begin
    rs1_data = regs_q[rs1_idx];
    if (rs1_idx == '0) rs1_data = '0;
    else if (bus.w_regs_en && bus.w_regs_addr == rs1_idx) rs1_data = bus.w_regs_data;
    rs2_data = regs_q[rs2_idx];
    if (rs2_idx == '0) rs2_data = '0;
    else if (bus.w_regs_en && bus.w_regs_addr == rs2_idx) rs2_data = bus.w_regs_data;
  end

  always_comb begin
    dec       = '0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    dec.valid = bus.id_valid;
    dec.pc    = bus.id_pc;
    dec.d1    = rs1_data;
    dec.d2    = rs2_data;
    dec.f3    = inst[14:12];
    dec.f7    = inst[30];
    dec.rd    = inst[7 +: RAW];
    dec.rs1   = rs1_idx;
    dec.rs2   = rs2_idx;
    case (inst[6:0])
      OpLoad: begin
        dec.mem_read   = 1'b1;
        dec.mem2reg    = 1'b1;
        dec.alu_src    = 1'b1;
        dec.regs_write = 1'b1;
        dec.alu_op     = 3'b000;
        dec.imm        = {{(XLEN-12){inst[31]}}, inst[31:20]};
        rs1_used       = 1'b1;
      end
      OpStore: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = 3'b000;
        dec.imm       = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
      end
      OpBranch: begin
        dec.br     = 1'b1;
        dec.alu_op = 3'b001;
        dec.imm    = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
      end
      OpReg: begin
        dec.regs_write = 1'b1;
        dec.alu_op     = 3'b010;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OpImm: begin
        dec.regs_write = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_op     = 3'b011;
        dec.imm        = {{(XLEN-12){inst[31]}}, inst[31:20]};
        rs1_used       = 1'b1;
      end
      default: ;
    endcase
    if (!bus.id_valid) begin
      dec.br         = 1'b0;
      dec.mem_read   = 1'b0;
      dec.mem2reg    = 1'b0;
      dec.mem_write  = 1'b0;
      dec.alu_src    = 1'b0;
      dec.regs_write = 1'b0;
      dec.alu_op     = 3'b000;
    end
  end

  assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && bus.id_valid &&
                  ((rs1_used && rs1_idx == ex_q.rd) || (rs2_used && rs2_idx == ex_q.rd));

  assign bus.id_stall = hazard | bus.ex_hold;

  // Flush beats hold: a killed instruction must never survive a downstream stall.
  always_comb begin
    if (bus.flush)        ex_d = '0;
    else if (bus.ex_hold) ex_d = ex_q;
    else if (hazard)      ex_d = '0;
    else                  ex_d = dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_regs_data1 = ex_q.d1;
  assign bus.ex_regs_data2 = ex_q.d2;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_func3_code = ex_q.f3;
  assign bus.ex_func7_code = ex_q.f7;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_rs1        = ex_q.rs1;
  assign bus.ex_rs2        = ex_q.rs2;
  assign bus.ex_br         = ex_q.br;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem2reg    = ex_q.mem2reg;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_regs_write = ex_q.regs_write;
  assign bus.ex_alu_op     = ex_q.alu_op;

`ifdef STAGE_ID_PERF_EN
  logic [31:0] perf_bubbles_d, perf_bubbles_q;
  logic [31:0] perf_flushes_d, perf_flushes_q;

  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    perf_flushes_d = perf_flushes_q;
    // Only count bubbles the hazard actually loaded (not shadowed by flush/hold).
    if (!bus.flush && !bus.ex_hold && hazard && perf_bubbles_q != '1)
      perf_bubbles_d = perf_bubbles_q + 32'd1;
    if (bus.flush && perf_flushes_q != '1) perf_flushes_d = perf_flushes_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubbles_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_bubbles_q <= perf_bubbles_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_flushes = perf_flushes_q;
`endif
endmodule

// File: doc/stage_id_pipe.md
Name: stage_id_pipe

Overview:
- Parametrised decode stage for the 5-stage RISC-V pipeline.
- Contains:
  - the register file with write-through bypass;
  - control decode and immediate generation;
  - load-use hazard detection;
  - the registered ID/EX pipeline boundary, with hold, bubble and flush.
- Sits between the IF/ID register and the execute stage.
- Produces a single stall request to the fetch side.

Parameters:
XLEN, 32, datapath and register width in bits.
NREG, 32, architectural register count (power of two, ≥2); RAW = log2(NREG).
PCW, 32, program-counter width carried through to EX.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  id_inst/id_pc hold a real instruction
id_inst  in  32  instruction word
id_pc  in  PCW  instruction address
w_regs_en  in  1  writeback enable
w_regs_addr  in  RAW  writeback register index
w_regs_data  in  XLEN  writeback data
ex_hold  in  1  downstream stall: freeze ID/EX register
flush  in  1  taken branch: kill the instruction in ID
id_stall  out  1  fetch/IF-ID must hold = load-use hazard OR ex_hold
ex_valid  out  1  ID/EX holds a real instruction
ex_pc  out  PCW  registered pc
ex_regs_data1, ex_regs_data2  out  XLEN  registered operands
ex_imm  out  XLEN  registered sign-extended immediate
ex_func3_code  out  3  inst[14:12]
ex_func7_code  out  1  inst[30]
ex_rd, ex_rs1, ex_rs2  out  RAW  register indices (low RAW bits of fields)
ex_br, ex_mem_read, ex_mem2reg, ex_mem_write, ex_alu_src, ex_regs_write  out  1  control
ex_alu_op  out  3  ALU class

Behaviour:
- Reset (async): register file all zero; every ex_* output 0; id_stall follows combinational logic.
- Register file:
  - x0 reads 0 and is never written.
  - Writes occur at the clock edge when w_regs_en=1 and addr≠0.
  - Same-cycle read of the register being written (addr≠0) returns w_regs_data (write-through bypass).
- Decode on inst[6:0]:
  - LOAD 0000011: mem_read=1, mem2reg=1, alu_src=1, regs_write=1, alu_op=000, I-imm.
  - STORE 0100011: mem_write=1, alu_src=1, alu_op=000, S-imm.
  - BRANCH 1100011: br=1, alu_op=001, B-imm (bit0=0).
  - OP 0110011: regs_write=1, alu_op=010, imm=0.
  - OP-IMM 0010011: regs_write=1, alu_src=1, alu_op=011, I-imm.
  - Any other opcode: all control 0, imm=0.
  - Immediates are sign-extended from inst[31] to XLEN.
- rs usage:
  - rs1 is used by LOAD, STORE, BRANCH, OP and OP-IMM.
  - rs2 is used by STORE, BRANCH and OP.
- Load-use hazard = ex_valid & ex_mem_read & ex_rd≠0 & id_valid & ((rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd)).
- ID/EX update priority at each edge:
  1. flush=1: load a bubble, even if ex_hold=1.
  2. ex_hold=1: keep all ex_* values.
  3. hazard=1: load a bubble.
  4. otherwise: load the decoded instruction; ex_valid=id_valid; if id_valid=0, all control 0.
- Bubble = ex_valid 0, all control 0, data/index fields 0.
- Latency: decode → ex_* visible exactly 1 cycle after the capturing edge.
- A hazard lasts exactly 1 cycle: the bubble clears ex_mem_read.

Optional Feature:
STAGE_ID_PERF_EN
- Defined: adds outputs perf_bubbles[31:0] (edges that loaded a hazard bubble) and perf_flushes[31:0] (edges with flush=1).
  - Both counters saturate at 32'hFFFFFFFF.
  - Both reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-run, then write x5=0x1234 and read rs1=5 in the same cycle → decoded operand 0x1234 (bypass); ex_regs_data1=0x1234 next cycle; writing x0=0xFFFF reads back 0.
- `lw x3,8(x1)` followed by `add x4,x3,x2` → id_stall=1 for one cycle, one bubble (ex_valid=0, ex_regs_write=0), then the add enters with ex_rd=4 and alu_op=010.
- `lw x3` followed by `addi x4,x0,-1` (rs1=0) → no stall; ex_imm=0xFFFFFFFF.
- STORE imm=-4 → ex_imm=0xFFFFFFFC; BRANCH offset +2048 → ex_imm=0x00000800.
- ex_hold=1 for 3 cycles with varying id_inst → ex_* frozen and id_stall=1; flush asserted during the hold → bubble loaded.
- With STAGE_ID_PERF_EN: 2 hazards + 3 flushes → perf_bubbles=2, perf_flushes=3.
